load_route_ctrl: RTL and testbench

Layer-level sequencer between the host data stream and the accelerator `top`. On a start command it moves a weight block, then an input block, from a valid/ready stream into the scratchpads, using the `top` write port (`write_en`/`write_addr`/`spad_select`/`data_in`). It then clears the PE registers and holds `route_en` until the datapath reports completion. It replaces hand-driven load and route sequencing with a single start/done handshake.

---
 rtl/load_route_ctrl_if.sv | 24 ++
 rtl/load_route_ctrl.sv | 149 ++++++++++++++
 tb/tb_load_route_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/load_route_ctrl_if.sv
// Stream-in and scratchpad write-port bundle for load_route_ctrl.
// slave = controller side, master = host/datapath side.
interface load_route_ctrl_if #(
   parameter int unsigned SRAM_DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH      = 8
);
   logic [SRAM_DATA_WIDTH-1:0] i_s_data;
   logic                       i_s_valid;
   logic                       o_s_ready;
   logic                       o_write_en;
   logic [ADDR_WIDTH-1:0]      o_write_addr;
   logic [1:0]                 o_spad_select;
   logic [SRAM_DATA_WIDTH-1:0] o_data_in;

   modport slave (
      input  i_s_data, i_s_valid,
      output o_s_ready, o_write_en, o_write_addr, o_spad_select, o_data_in
   );

   modport master (
      output i_s_data, i_s_valid,
      input  o_s_ready, o_write_en, o_write_addr, o_spad_select, o_data_in
   );
endinterface

// File: rtl/load_route_ctrl.sv
// Layer sequencer: loads weight then input blocks from a valid/ready stream into
// the scratchpads, clears the PE registers, then routes until the datapath is done.
module load_route_ctrl #(
   parameter int unsigned SRAM_DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH      = 8
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [ADDR_WIDTH:0]   i_w_count,
   input  logic [ADDR_WIDTH:0]   i_i_count,
   load_route_ctrl_if.slave      bus,
   output logic [ADDR_WIDTH-1:0] o_i_addr_end,
   output logic                  o_reg_clear,
   output logic                  o_route_en,
   input  logic                  i_route_done,
   output logic                  o_busy,
   output logic                  o_done
);

   typedef enum logic [2:0] {
      IDLE, LOAD_W, LOAD_I, SETTLE, CLEAR, ROUTE, DONE
   } state_t;

   localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                     state_q, state_d;
   logic [ADDR_WIDTH:0]        w_cnt_q, w_cnt_d;
   logic [ADDR_WIDTH:0]        i_cnt_q, i_cnt_d;
   logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]      iend_q, iend_d;
   logic                       wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
   logic [1:0]                 wr_sel_q, wr_sel_d;
   logic [SRAM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   logic                       s_ready;
   logic                       hs;
   logic                       last_word;
   logic [ADDR_WIDTH:0]        w_sat, i_sat, phase_cnt;

   function automatic logic [ADDR_WIDTH:0] sat_cnt(input logic [ADDR_WIDTH:0] c);
      return (c > CNT_MAX) ? CNT_MAX : c;
   endfunction

   always_comb begin
      w_sat     = sat_cnt(i_w_count);
      i_sat     = sat_cnt(i_i_count);
      s_ready   = (state_q == LOAD_W) || (state_q == LOAD_I);
      hs        = bus.i_s_valid & s_ready;
      phase_cnt = (state_q == LOAD_W) ? w_cnt_q : i_cnt_q;
      // Compare one bit wider so a full 2^ADDR_WIDTH phase ends at the top address.
      last_word = ({1'b0, addr_q} == (phase_cnt - CNT_ONE));
   end

   always_comb begin
      state_d   = state_q;
      w_cnt_d   = w_cnt_q;
      i_cnt_d   = i_cnt_q;
      addr_d    = addr_q;
      iend_d    = iend_q;
      wr_en_d   = hs;
      wr_addr_d = hs ? addr_q : wr_addr_q;
      wr_sel_d  = hs ? ((state_q == LOAD_I) ? 2'd1 : 2'd0) : wr_sel_q;
      wr_data_d = hs ? bus.i_s_data : wr_data_q;

      unique case (state_q)
         IDLE: begin
            if (i_start && !i_abort) begin
               w_cnt_d = w_sat;
               i_cnt_d = i_sat;
               iend_d  = (i_sat == '0) ? '0 : ADDR_WIDTH'(i_sat - CNT_ONE);
               if (w_sat != '0)      state_d = LOAD_W;
               else if (i_sat != '0) state_d = LOAD_I;
               else                  state_d = SETTLE;
            end
         end
         LOAD_W: begin
            if (hs) begin
               if (last_word) begin
                  addr_d  = '0;
                  state_d = (i_cnt_q != '0) ? LOAD_I : SETTLE;
               end else begin
                  addr_d = addr_q + ADDR_WIDTH'(1);
               end
            end
         end
         LOAD_I: begin
            if (hs) begin
               if (last_word) begin
                  addr_d  = '0;
                  state_d = SETTLE;
               end else begin
                  addr_d = addr_q + ADDR_WIDTH'(1);
               end
            end
         end
         SETTLE: state_d = CLEAR;
         CLEAR:  state_d = ROUTE;
         ROUTE:  if (i_route_done) state_d = DONE;
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A write registered in the abort cycle still goes out; only sequencing stops.
      if (i_abort) begin
         state_d = IDLE;
         addr_d  = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state_q   <= IDLE;
         w_cnt_q   <= '0;
         i_cnt_q   <= '0;
         addr_q    <= '0;
         iend_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_sel_q  <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         w_cnt_q   <= w_cnt_d;
         i_cnt_q   <= i_cnt_d;
         addr_q    <= addr_d;
         iend_q    <= iend_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_sel_q  <= wr_sel_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.o_s_ready     = s_ready;
   assign bus.o_write_en    = wr_en_q;
   assign bus.o_write_addr  = wr_addr_q;
   assign bus.o_spad_select = wr_sel_q;
   assign bus.o_data_in     = wr_data_q;
   assign o_i_addr_end      = iend_q;
   assign o_reg_clear       = (state_q == CLEAR);
   assign o_route_en        = (state_q == ROUTE);
   assign o_done            = (state_q == DONE);
   assign o_busy            = (state_q != IDLE);

endmodule

// File: tb/tb_load_route_ctrl.sv
// Bench for load_route_ctrl: table of load/route runs, plus abort and reset sequences.
module tb_load_route_ctrl;
   localparam int unsigned DW = 64;
   localparam int unsigned AW = 8;

   typedef struct packed {
      logic [1:0]    sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      int unsigned w;
      int unsigned i;
      bit          tog;
      int unsigned nw;
      int unsigned ni;
      int unsigned iend;
   } vec_t;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          route_done = 1'b0;
   logic [AW:0]   wcnt = '0;
   logic [AW:0]   icnt = '0;
   logic [AW-1:0] iend;
   logic          reg_clear, route_en, busy, done;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned writes_seen = 0;
   wr_t         exp_q[$];
   vec_t        vecs[6];

   load_route_ctrl_if #(.SRAM_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   load_route_ctrl #(.SRAM_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk       (clk),
      .i_nrst      (nrst),
      .i_start     (start),
      .i_abort     (abort),
      .i_w_count   (wcnt),
      .i_i_count   (icnt),
      .bus         (bus.slave),
      .o_i_addr_end(iend),
      .o_reg_clear (reg_clear),
      .o_route_en  (route_en),
      .i_route_done(route_done),
      .o_busy      (busy),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] data_of(input int unsigned g);
      return {32'hD47A0000 ^ g, ~g};
   endfunction

   // Scoreboard: every presented write must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.o_write_en === 1'b1) begin
         writes_seen++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", 80'({bus.o_spad_select, bus.o_write_addr}), 80'h3FF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write", 80'({bus.o_spad_select, bus.o_write_addr, bus.o_data_in}), 80'(e));
         end
      end
   end

   task automatic push_writes(input int unsigned nw, input int unsigned ni);
      for (int unsigned a = 0; a < nw; a++)
         exp_q.push_back('{sel: 2'd0, addr: AW'(a), data: data_of(a)});
      for (int unsigned a = 0; a < ni; a++)
         exp_q.push_back('{sel: 2'd1, addr: AW'(a), data: data_of(nw + a)});
   endtask

   // Called at a negedge; returns at the negedge whose valid completes the n-th handshake.
   task automatic drive_words(input int unsigned n, input bit tog);
      int unsigned sent = 0;
      int unsigned cyc = 0;
      while (sent < n && cyc < 4 * n + 20) begin
         bus.i_s_valid = tog ? (cyc[0] == 1'b0) : 1'b1;
         bus.i_s_data  = data_of(sent);
         if (bus.i_s_valid && bus.o_s_ready === 1'b1) sent++;
         cyc++;
         if (sent < n) @(negedge clk);
      end
      if (sent < n) check("handshake_timeout", 80'(sent), 80'(n));
   endtask

   task automatic run_case(input int unsigned w, input int unsigned i, input bit tog,
                           input int unsigned nw, input int unsigned ni, input int unsigned exp_end);
      int unsigned w0;
      w0 = writes_seen;
      push_writes(nw, ni);
      @(negedge clk);
      wcnt  = (AW+1)'(w);
      icnt  = (AW+1)'(i);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (nw + ni > 0) begin
         check("load_ready", 80'(bus.o_s_ready), 80'(1));
         drive_words(nw + ni, tog);
         @(negedge clk);
         bus.i_s_valid = 1'b0;
      end
      check("settle", 80'({bus.o_s_ready, reg_clear, route_en, busy}), 80'(4'b0001));
      @(negedge clk);
      check("clear", 80'({reg_clear, route_en, busy}), 80'(3'b101));
      @(negedge clk);
      check("route", 80'({reg_clear, route_en, busy, done}), 80'(4'b0110));
      check("i_addr_end", 80'(iend), 80'(exp_end));
      @(negedge clk);
      check("route_hold", 80'(route_en), 80'(1));
      route_done = 1'b1;
      @(negedge clk);
      route_done = 1'b0;
      check("done", 80'({route_en, done, busy}), 80'(3'b011));
      @(negedge clk);
      check("idle", 80'({route_en, done, busy}), 80'(3'b000));
      check("write_count", 80'(writes_seen - w0), 80'(nw + ni));
      check("queue_empty", 80'(exp_q.size()), 80'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{w: 9,   i: 25,  tog: 1'b0, nw: 9,   ni: 25,  iend: 24};
      vecs[1] = '{w: 9,   i: 25,  tog: 1'b1, nw: 9,   ni: 25,  iend: 24};
      vecs[2] = '{w: 0,   i: 4,   tog: 1'b0, nw: 0,   ni: 4,   iend: 3};
      vecs[3] = '{w: 0,   i: 0,   tog: 1'b0, nw: 0,   ni: 0,   iend: 0};
      vecs[4] = '{w: 256, i: 256, tog: 1'b0, nw: 256, ni: 256, iend: 255};
      vecs[5] = '{w: 2,   i: 511, tog: 1'b1, nw: 2,   ni: 256, iend: 255};

      bus.i_s_valid = 1'b0;
      bus.i_s_data  = '0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 80'({bus.o_s_ready, bus.o_write_en, reg_clear, route_en, busy, done}), 80'(0));
      check("reset_addr", 80'({bus.o_write_addr, bus.o_spad_select, iend}), 80'(0));
      check("reset_data", 80'(bus.o_data_in), 80'(0));
      nrst = 1'b1;

      foreach (vecs[k])
         run_case(vecs[k].w, vecs[k].i, vecs[k].tog, vecs[k].nw, vecs[k].ni, vecs[k].iend);

      // Abort together with start in IDLE: no start accepted.
      @(negedge clk);
      start = 1'b1; abort = 1'b1; wcnt = 9'd3; icnt = 9'd3;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start_idle", 80'({busy, bus.o_s_ready}), 80'(0));

      // Abort after five weight handshakes.
      push_writes(5, 0);
      @(negedge clk);
      wcnt = 9'd9; icnt = 9'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive_words(5, 1'b0);
      @(negedge clk);
      bus.i_s_valid = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", 80'({busy, done, bus.o_s_ready, bus.o_write_en, route_en}), 80'(0));
      @(negedge clk);
      check("abort_no_done", 80'({busy, done}), 80'(0));
      check("abort_queue", 80'(exp_q.size()), 80'(0));
      run_case(2, 2, 1'b0, 2, 2, 1);

      // Reset mid-LOAD_I with start held high across the reset edge.
      push_writes(2, 2);
      @(negedge clk);
      wcnt = 9'd2; icnt = 9'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive_words(4, 1'b0);
      @(negedge clk);
      bus.i_s_valid = 1'b0;
      nrst = 1'b0;
      start = 1'b1;
      @(negedge clk);
      nrst = 1'b1;
      start = 1'b0;
      check("rst_mid_ctrl", 80'({bus.o_s_ready, bus.o_write_en, reg_clear, route_en, busy, done}), 80'(0));
      check("rst_mid_addr", 80'({bus.o_write_addr, bus.o_spad_select, iend}), 80'(0));
      check("rst_mid_data", 80'(bus.o_data_in), 80'(0));
      @(negedge clk);
      check("rst_start_ignored", 80'({busy, bus.o_s_ready}), 80'(0));
      check("rst_queue", 80'(exp_q.size()), 80'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
